// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared FSM state, BCD digit type and digit-range helper for bcd_sub_seq.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    CMPL = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic logic bcd_bad(input bcd_digit_t dig);
    return dig > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// rtl/bcd_digit_sub.sv - one BCD digit subtract with borrow: d = x - y - bin, corrected by +10 on underflow.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t x,
  input  bcd_digit_t y,
  input  logic       bin,
  output bcd_digit_t d,
  output logic       bout
);

  logic [4:0] t;

  always_comb begin
    t    = {1'b0, x} - {1'b0, y} - {4'b0000, bin};
    bout = t[4];
    // A negative 5-bit result wraps mod 16, so adding 10 in 4 bits lands on the right digit.
    d    = t[4] ? (t[3:0] + 4'd10) : t[3:0];
  end

endmodule

// File: rtl/bcd_sub_seq.sv
// rtl/bcd_sub_seq.sv - sequential packed-BCD |a-b|, one digit per cycle; BCD_CHECK_EN adds the invalid output.
module bcd_sub_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                neg
`ifdef BCD_CHECK_EN
  ,
  output logic                invalid
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t        state, state_nx;
  logic [W-1:0]  a_sh, b_sh, res, res_shift;
  logic [IW-1:0] idx;
  logic          borrow;
  logic          last;
  bcd_digit_t    dx, dy, dd;
  logic          dbout;

  // CMPL reuses the same digit subtractor as 0 - raw digit.
  assign dx = (state == CMPL) ? 4'd0 : a_sh[3:0];
  assign dy = (state == CMPL) ? res[3:0] : b_sh[3:0];

  bcd_digit_sub u_digit (
    .x   (dx),
    .y   (dy),
    .bin (borrow),
    .d   (dd),
    .bout(dbout)
  );

  // Result digits enter at the top so that after DIGITS steps digit 0 sits in bits [3:0].
  generate
    if (DIGITS > 1) begin : g_multi
      assign res_shift = {dd, res[W-1:4]};
    end else begin : g_single
      assign res_shift = dd;
    end
  endgenerate

  assign last = (idx == IW'(DIGITS - 1));
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SUB;
      SUB:     if (last) state_nx = dbout ? CMPL : DONE;
      CMPL:    if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef BCD_CHECK_EN
  logic bad_sticky;
  logic bad_now;

  assign bad_now = bcd_bad(a_sh[3:0]) | bcd_bad(b_sh[3:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      bad_sticky <= 1'b0;
      invalid    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) bad_sticky <= 1'b0;
        SUB: begin
          bad_sticky <= bad_sticky | bad_now;
          if (last && !dbout) invalid <= bad_sticky | bad_now;
        end
        CMPL: if (last) invalid <= bad_sticky;
        default: ;
      endcase
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      neg    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            res    <= '0;
            idx    <= '0;
            borrow <= 1'b0;
          end
        end
        SUB: begin
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          res    <= res_shift;
          borrow <= last ? 1'b0 : dbout;
          idx    <= last ? '0 : idx + 1'b1;
          if (last && !dbout) begin
            diff <= res_shift;
            neg  <= 1'b0;
          end
        end
        CMPL: begin
          res    <= res_shift;
          borrow <= dbout;
          idx    <= last ? '0 : idx + 1'b1;
          if (last) begin
            diff <= res_shift;
            neg  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_sub_seq.sv
// tb/tb_bcd_sub_seq.sv - directed, table-driven self-checking bench for bcd_sub_seq (DIGITS=4).
module tb_bcd_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done, neg;
  logic [15:0] diff;
`ifdef BCD_CHECK_EN
  logic        invalid;
`endif

  int checks   = 0;
  int failures = 0;

  bcd_sub_seq #(.DIGITS(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .neg    (neg)
`ifdef BCD_CHECK_EN
    ,
    .invalid(invalid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] diff;
    logic        neg;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Drives start for edge 0, then scrambles a/b so late changes would show up.
  task automatic launch(input logic [15:0] aa, input logic [15:0] bb);
    start = 1'b1;
    a     = aa;
    b     = bb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 16'h1234;
    b     = 16'h8765;
  endtask

  // Called #1 after edge 0; cycle 1 begins at edge 0.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  vec_t vecs[8];
  int   cyc;
  int   ndone;

  initial begin
    vecs[0] = '{16'h0753, 16'h0432, 16'h0321, 1'b0, 5};
    vecs[1] = '{16'h0432, 16'h0753, 16'h0321, 1'b1, 9};
    vecs[2] = '{16'h0000, 16'h9999, 16'h9999, 1'b1, 9};
    vecs[3] = '{16'h9999, 16'h0001, 16'h9998, 1'b0, 5};
    vecs[4] = '{16'h0500, 16'h0500, 16'h0000, 1'b0, 5};
    vecs[5] = '{16'h1000, 16'h0001, 16'h0999, 1'b0, 5};
    vecs[6] = '{16'h0001, 16'h1000, 16'h0999, 1'b1, 9};
    vecs[7] = '{16'h5000, 16'h4999, 16'h0001, 1'b0, 5};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_diff", diff, 0);
    check("reset_neg", neg, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy_cycle1", i), busy, 1);
      wait_done(cyc);
      check($sformatf("v%0d_latency", i), cyc, vecs[i].lat);
      check($sformatf("v%0d_diff", i), diff, vecs[i].diff);
      check($sformatf("v%0d_neg", i), neg, vecs[i].neg);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), done, 0);
      check($sformatf("v%0d_idle", i), busy, 0);
      check($sformatf("v%0d_diff_hold", i), diff, vecs[i].diff);
    end

    // A second start while busy must not produce a second done.
    launch(16'h0500, 16'h0500);
    start = 1'b1;
    a     = 16'h0900;
    b     = 16'h0100;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) ndone++;
      @(posedge clk);
      #1;
    end
    check("busy_start_done_count", ndone, 1);
    check("busy_start_diff", diff, 16'h0000);
    check("busy_start_neg", neg, 0);

    // start held during DONE is ignored, then accepted from IDLE.
    launch(16'h0753, 16'h0432);
    wait_done(cyc);
    check("done_start_latency", cyc, 5);
    start = 1'b1;
    a     = 16'h0002;
    b     = 16'h0001;
    @(posedge clk);
    #1;
    check("done_start_ignored", busy, 0);
    @(posedge clk);
    #1;
    check("idle_start_accepted", busy, 1);
    start = 1'b0;
    wait_done(cyc);
    check("idle_start_latency", cyc, 5);
    check("idle_start_diff", diff, 16'h0001);
    @(posedge clk);
    #1;

    // Reset in cycle 3 aborts the operation and clears outputs.
    launch(16'h0432, 16'h0753);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_diff", diff, 0);
    check("abort_neg", neg, 0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (done === 1'b1) ndone++;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", ndone, 0);
    launch(16'h0432, 16'h0753);
    wait_done(cyc);
    check("after_abort_latency", cyc, 9);
    check("after_abort_diff", diff, 16'h0321);
    check("after_abort_neg", neg, 1);
    @(posedge clk);
    #1;

    // Reset wins over a simultaneous start.
    rst   = 1'b1;
    start = 1'b1;
    a     = 16'h0001;
    b     = 16'h0000;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    check("rst_over_start", busy, 0);
    @(posedge clk);
    #1;

`ifdef BCD_CHECK_EN
    launch(16'h00A0, 16'h0001);
    wait_done(cyc);
    check("invalid_latency", cyc, 5);
    check("invalid_set", invalid, 1);
    @(posedge clk);
    #1;
    check("invalid_hold", invalid, 1);
    launch(16'h0753, 16'h0432);
    wait_done(cyc);
    check("invalid_cleared", invalid, 0);
    check("invalid_clear_diff", diff, 16'h0321);
    @(posedge clk);
    #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
